// File: rtl/ov7670_fb_reader_if.sv
// ----------------------------------------------------------------------------
// ov7670_fb_reader_if
// Purpose : groups the VGA timing inputs, the frame-buffer read port and the
//           delayed VGA/pixel outputs used by ov7670_fb_reader.
// Signals :
//   hcount_in, vcount_in  11  VGA raster counters
//   hsync_in, vsync_in     1  VGA sync
//   hblnk_in, vblnk_in     1  VGA blanking
//   fb_data               12  frame-buffer read data {R,G,B} (RGB444)
//   fb_addr               19  frame-buffer read address
//   rgb_out               12  pixel colour, zero while blanked
//   hsync_out, vsync_out,
//   hblnk_out, vblnk_out   1  timing aligned with rgb_out
// Modports: slave = the reader, master = the timing source / RAM / sink side.
// ----------------------------------------------------------------------------
interface ov7670_fb_reader_if;
    logic [10:0] hcount_in;
    logic [10:0] vcount_in;
    logic        hsync_in;
    logic        vsync_in;
    logic        hblnk_in;
    logic        vblnk_in;
    logic [11:0] fb_data;
    logic [18:0] fb_addr;
    logic [11:0] rgb_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        hblnk_out;
    logic        vblnk_out;

    modport slave (
        input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, fb_data,
        output fb_addr, rgb_out, hsync_out, vsync_out, hblnk_out, vblnk_out
    );

    modport master (
        output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, fb_data,
        input  fb_addr, rgb_out, hsync_out, vsync_out, hblnk_out, vblnk_out
    );
endinterface

// File: rtl/ov7670_fb_reader.sv
// ----------------------------------------------------------------------------
// ov7670_fb_reader
// Purpose : reads the row-major RGB444 frame buffer filled by the OV7670
//           capture stage and streams it onto a 640x480 VGA raster. 320x240
//           and 160x120 frames are upscaled by pixel/line replication.
//           Addresses are generated incrementally (no multipliers).
// Ports   :
//   clk          VGA pixel clock
//   rst_n        asynchronous active-low reset
//   rez_160x120  buffer holds a 160x120 frame (wins over rez_320x240)
//   rez_320x240  buffer holds a 320x240 frame
//   fb_bus       ov7670_fb_reader_if.slave: VGA timing in, RAM read port,
//                RGB and delayed timing out
// Latency : rgb_out and *_out lag the VGA inputs by RAM_LATENCY+1 edges.
// ----------------------------------------------------------------------------
module ov7670_fb_reader #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned RAM_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rez_160x120,
    input  logic                     rez_320x240,
    ov7670_fb_reader_if.slave        fb_bus
);

    localparam int unsigned DEPTH = RAM_LATENCY + 1;
    localparam int unsigned COL_W = $clog2(H_ACTIVE + 1);

    localparam logic [1:0] MODE_FULL = 2'd0;
    localparam logic [1:0] MODE_320  = 2'd1;
    localparam logic [1:0] MODE_160  = 2'd2;

    localparam logic [18:0] W_FULL = 19'(H_ACTIVE);
    localparam logic [18:0] W_320  = 19'(H_ACTIVE / 2);
    localparam logic [18:0] W_160  = 19'(H_ACTIVE / 4);

    localparam logic [18:0] MAX_FULL = 19'(H_ACTIVE * V_ACTIVE - 1);
    localparam logic [18:0] MAX_320  = 19'((H_ACTIVE / 2) * (V_ACTIVE / 2) - 1);
    localparam logic [18:0] MAX_160  = 19'((H_ACTIVE / 4) * (V_ACTIVE / 4) - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]       r_mode;
    logic             r_valid;       // a frame start has been seen since reset
    logic             r_hblnk_prev;
    logic [COL_W-1:0] r_col;
    logic [1:0]       r_hrep;
    logic [1:0]       r_vrep;
    logic [18:0]      r_row_base;
    logic [18:0]      r_fb_addr;
    logic [DEPTH-1:0] r_hs_pipe;
    logic [DEPTH-1:0] r_vs_pipe;
    logic [DEPTH-1:0] r_hb_pipe;
    logic [DEPTH-1:0] r_vb_pipe;

    // ------------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------------
    logic             w_frame_start;
    logic             w_active;
    logic             w_hblnk_rise;
    logic             w_valid;
    logic [1:0]       w_mode_new;
    logic [1:0]       w_mode;
    logic [1:0]       w_scale_m1;
    logic [18:0]      w_width;
    logic [18:0]      w_addr_max;
    logic [COL_W-1:0] w_col;
    logic [1:0]       w_hrep;
    logic [1:0]       w_vrep;
    logic [18:0]      w_row_base;
    logic [18:0]      w_addr;
    logic             w_hs_gated;
    logic             w_vs_gated;
    logic             w_hb_gated;
    logic             w_vb_gated;
    logic             w_blank_out;

    assign w_frame_start = (fb_bus.hcount_in == 11'd0) && (fb_bus.vcount_in == 11'd0);
    assign w_active      = !fb_bus.hblnk_in && !fb_bus.vblnk_in;
    assign w_hblnk_rise  = fb_bus.hblnk_in && !r_hblnk_prev;
    assign w_valid       = r_valid || w_frame_start;

    assign w_mode_new = rez_160x120 ? MODE_160 : (rez_320x240 ? MODE_320 : MODE_FULL);
    // The frame-start pixel itself already uses the newly latched mode.
    assign w_mode     = w_frame_start ? w_mode_new : r_mode;

    always_comb begin
        w_scale_m1 = 2'd0;
        w_width    = W_FULL;
        w_addr_max = MAX_FULL;
        unique case (w_mode)
            MODE_160: begin
                w_scale_m1 = 2'd3;
                w_width    = W_160;
                w_addr_max = MAX_160;
            end
            MODE_320: begin
                w_scale_m1 = 2'd1;
                w_width    = W_320;
                w_addr_max = MAX_320;
            end
            default: begin
                w_scale_m1 = 2'd0;
                w_width    = W_FULL;
                w_addr_max = MAX_FULL;
            end
        endcase
    end

    // Counter values as seen by the current pixel: a frame start restarts the
    // raster so pixel (0,0) reads address 0 whatever the counters held.
    assign w_col      = w_frame_start ? '0 : r_col;
    assign w_hrep     = w_frame_start ? 2'd0 : r_hrep;
    assign w_vrep     = w_frame_start ? 2'd0 : r_vrep;
    assign w_row_base = w_frame_start ? 19'd0 : r_row_base;

    assign w_addr = w_row_base + {{(19 - COL_W){1'b0}}, w_col};

    // Until the first frame start the timing pipe is fed its reset values so
    // that the output stays blanked.
    assign w_hs_gated = w_valid ? fb_bus.hsync_in : 1'b0;
    assign w_vs_gated = w_valid ? fb_bus.vsync_in : 1'b0;
    assign w_hb_gated = w_valid ? fb_bus.hblnk_in : 1'b1;
    assign w_vb_gated = w_valid ? fb_bus.vblnk_in : 1'b1;

    // ------------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode       <= MODE_FULL;
            r_valid      <= 1'b0;
            r_hblnk_prev <= 1'b1;
            r_col        <= '0;
            r_hrep       <= 2'd0;
            r_vrep       <= 2'd0;
            r_row_base   <= 19'd0;
            r_fb_addr    <= 19'd0;
            r_hs_pipe    <= '0;
            r_vs_pipe    <= '0;
            r_hb_pipe    <= '1;
            r_vb_pipe    <= '1;
        end else begin
            r_mode       <= w_mode;
            r_valid      <= w_valid;
            r_hblnk_prev <= fb_bus.hblnk_in;

            // Horizontal: the column only moves on active pixels, so extra
            // blanking cycles on long lines never advance it.
            if (w_hblnk_rise) begin
                r_col  <= '0;
                r_hrep <= 2'd0;
            end else if (w_active) begin
                if (w_hrep == w_scale_m1) begin
                    r_hrep <= 2'd0;
                    r_col  <= w_col + COL_W'(1);
                end else begin
                    r_hrep <= w_hrep + 2'd1;
                    r_col  <= w_col;
                end
            end else begin
                r_col  <= w_col;
                r_hrep <= w_hrep;
            end

            // Vertical: one step per displayed line, taken at its hblnk rise.
            if (w_hblnk_rise && !fb_bus.vblnk_in) begin
                if (w_vrep == w_scale_m1) begin
                    r_vrep     <= 2'd0;
                    r_row_base <= w_row_base + w_width;
                end else begin
                    r_vrep     <= w_vrep + 2'd1;
                    r_row_base <= w_row_base;
                end
            end else begin
                r_vrep     <= w_vrep;
                r_row_base <= w_row_base;
            end

            // Address holds through blanking.
            if (w_valid && w_active) begin
                r_fb_addr <= w_addr;
            end

            r_hs_pipe <= {r_hs_pipe[DEPTH-2:0], w_hs_gated};
            r_vs_pipe <= {r_vs_pipe[DEPTH-2:0], w_vs_gated};
            r_hb_pipe <= {r_hb_pipe[DEPTH-2:0], w_hb_gated};
            r_vb_pipe <= {r_vb_pipe[DEPTH-2:0], w_vb_gated};
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // The RAM's own read register is the final pixel stage, so rgb_out is only
    // masked here; this keeps the total lag at RAM_LATENCY+1.
    assign w_blank_out = r_hb_pipe[DEPTH-1] || r_vb_pipe[DEPTH-1];

    assign fb_bus.fb_addr   = r_fb_addr;
    assign fb_bus.rgb_out   = w_blank_out ? 12'h000 : fb_bus.fb_data;
    assign fb_bus.hsync_out = r_hs_pipe[DEPTH-1];
    assign fb_bus.vsync_out = r_vs_pipe[DEPTH-1];
    assign fb_bus.hblnk_out = r_hb_pipe[DEPTH-1];
    assign fb_bus.vblnk_out = r_vb_pipe[DEPTH-1];

    // The generated address must stay inside the frame of the active mode.
    a_addr_range: assert property (@(posedge clk) disable iff (!rst_n)
        (w_valid && w_active) |-> (w_addr <= w_addr_max));

endmodule
